mod_counter_param: RTL and testbench
====================================

Name: mod_counter_param

Overview:
- Parametrised synchronous modulo-N up/down counter. It is the next-generation replacement for the 4-bit toggle-enable ripple counter.
- All state is clocked by a single clock, so there are no derived clocks.
- Adds over the previous counter: direction control, parallel load, sync clear, wrap or saturate mode, enable prescaler, terminal-count pulse and sticky overflow flag.
- Used as the general event/timebase counter throughout the counters library.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 1.
- MODULUS, 16, count range 0..MODULUS-1; requires 2 <= MODULUS <= 2**WIDTH, elaboration error otherwise.
- SATURATE, 0, 0 = wrap at boundary, 1 = hold at boundary.
- PRESCALE, 1, counter steps once per PRESCALE enabled cycles; must be >= 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- T  in  1  count enable.
- up_dn  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value to load.
- clear  in  1  synchronous clear.
- ovf_clr  in  1  clears sticky overflow flag.
- Q  out  WIDTH  counter value, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky overflow/underflow flag, registered.

Behaviour:
- Interface: one clock, clk. Reset is reset_n, asynchronous and active-low.
- While reset_n=0: Q=0, tc=0, ovf=0, prescale count=0, taking effect immediately with no clock edge. The first count step may occur on the first rising edge after deassertion.
- Per-edge priority: clear > load > count.
- clear=1: Q<=0, prescale count<=0, tc<=0. ovf is unaffected.
- load=1 (clear=0): Q<=min(load_val, MODULUS-1), prescale count<=0, tc<=0. No count step occurs that cycle, even with T=1.
- Prescaler: tick=1 when T=1 and prescale count==PRESCALE-1.
  - While T=1 the prescale count increments and wraps to 0 on tick.
  - T=0 holds the prescale count.
  - PRESCALE=1 means tick==T.
- Step on tick only (no clear/load):
  - up: Q==MODULUS-1 is a boundary event; otherwise Q<=Q+1.
  - down: Q==0 is a boundary event; otherwise Q<=Q-1.
- Boundary event:
  - SATURATE=0: Q wraps (up to 0, down to MODULUS-1).
  - SATURATE=1: Q holds.
  - In both modes the cycle after the event has tc=1 for one cycle, and ovf<=1.
  - With SATURATE=1 and a tick on every cycle at the boundary, tc stays high on every such cycle.
- tc=0 on every cycle with no boundary event.
- ovf: set by a boundary event, cleared by ovf_clr. If both occur on the same edge, the set wins (ovf=1).
- An up_dn change takes effect on the next tick; the current Q is retained.
- Latency: all control inputs affect outputs on the next rising edge. Q, tc and ovf have no combinational path from any input.
- Arithmetic is WIDTH bits unsigned. Q never leaves 0..MODULUS-1 after reset.

Decomposition:
- Shared package counter_pkg:
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
  - MODE_WRAP=0, MODE_SAT=1.
  - A clog2-based width helper for the prescale counter, which is clog2(PRESCALE) bits with a minimum of 1.
- One sub-module, count_prescaler:
  - Parameter PRESCALE; ports clk, reset_n, T, restart, tick.
  - restart is driven by clear|load.
  - The top level holds the Q/tc/ovf logic.

Test Plan:
1. WIDTH=4, MODULUS=10, PRESCALE=1. After reset, up_dn=1, T=1 for 12 cycles -> Q goes 1..9,0,1,2; tc=1 only in the cycle Q first shows 0; ovf=1 from then on.
2. Same configuration, Q=0, up_dn=0, T=1 -> Q=9, tc pulses once, ovf=1. Then ovf_clr=1 -> ovf=0. ovf_clr asserted together with a boundary event -> ovf=1.
3. SATURATE=1, MODULUS=10. Count up with T=1 held -> Q reaches 9 and stays 9; tc=1 on every cycle after reaching 9; down from 0 holds at 0.
4. Q=4, T=1:
   - load=1, load_val=7 -> Q=7, with no increment that cycle.
   - load_val=13 -> Q=9.
   - clear=1 together with load=1 -> Q=0.
5. PRESCALE=3, T=1 -> Q steps every 3rd cycle. T=0 for 2 cycles mid-period, then T=1 -> step occurs after the remaining enabled cycles. load resets the prescale phase, so the next step is exactly 3 enabled cycles later.
6. Mid-count (Q=6, ovf=1), drop reset_n between clock edges -> Q=0, tc=0, ovf=0 immediately. Release reset_n with T=1 -> Q=1 on the first rising edge after release.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counters library: direction and boundary-mode
// encodings plus the width helper used to size the prescale counter.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // A prescale divide of 1 still needs a one-bit register to keep the port list uniform
    function automatic int presc_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enable prescaler: turns a level count-enable into a one-cycle tick on every
// PRESCALE-th enabled cycle. restart realigns the phase to the start of a period.
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic T,
    input  logic restart,
    output logic tick
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcount;

    assign tick = T && (pcount == LAST);

    // Phase counter advances only on enabled cycles and rolls over on the tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcount <= '0;
        end else if (restart) begin
            pcount <= '0;
        end else if (T) begin
            if (tick) begin
                pcount <= '0;
            end else begin
                pcount <= pcount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_counter_param.sv
// Parametrised modulo-N up/down counter with parallel load, sync clear,
// wrap/saturate boundary handling, enable prescaler, terminal-count pulse
// and sticky overflow flag. All outputs are registered.
module mod_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             T,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1) begin : g_bad_width
        $error("mod_counter_param: WIDTH must be >= 1");
    end
    if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
        $error("mod_counter_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mod_counter_param: PRESCALE must be >= 1");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic             tick;
    logic             restart;
    logic [WIDTH-1:0] q_next;
    logic             boundary;

    assign restart = clear | load;

    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .T       (T),
        .restart (restart),
        .tick    (tick)
    );

    // Next count value and boundary detection, honouring clear > load > count
    always_comb begin
        q_next   = Q;
        boundary = 1'b0;
        if (clear) begin
            q_next = '0;
        end else if (load) begin
            q_next = (load_val > MAXV) ? MAXV : load_val;
        end else if (tick) begin
            if (up_dn == DIR_UP) begin
                if (Q == MAXV) begin
                    boundary = 1'b1;
                    q_next   = (SATURATE == MODE_SAT) ? Q : '0;
                end else begin
                    q_next = Q + 1'b1;
                end
            end else begin
                if (Q == '0) begin
                    boundary = 1'b1;
                    q_next   = (SATURATE == MODE_SAT) ? Q : MAXV;
                end else begin
                    q_next = Q - 1'b1;
                end
            end
        end
    end

    // Register the count and the one-cycle terminal-count pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q  <= '0;
            tc <= 1'b0;
        end else begin
            Q  <= q_next;
            tc <= boundary;
        end
    end

    // Sticky overflow: a boundary event outranks a simultaneous clear request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (boundary) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter_param.sv
// Testbench for mod_counter_param: three instances (wrap, saturate, prescale-by-3)
// share one stimulus stream and are compared every cycle against a counting model.
module tb_mod_counter_param;

    localparam int W    = 4;
    localparam int M    = 10;
    localparam int NDUT = 3;

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic         T        = 1'b0;
    logic         up_dn    = 1'b1;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         clear    = 1'b0;
    logic         ovf_clr  = 1'b0;

    logic [W-1:0] qv   [NDUT];
    logic         tcv  [NDUT];
    logic         ovfv [NDUT];

    int numChecks = 0;
    int numErrors = 0;

    // Reference model state, one slot per instance
    int mq   [NDUT];
    int mpc  [NDUT];
    int mtc  [NDUT];
    int movf [NDUT];
    int msat [NDUT] = '{0, 1, 0};
    int mpre [NDUT] = '{1, 1, 3};

    always #5 clk = ~clk;

    mod_counter_param #(.WIDTH(W), .MODULUS(M), .SATURATE(0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .T(T), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear), .ovf_clr(ovf_clr),
        .Q(qv[0]), .tc(tcv[0]), .ovf(ovfv[0])
    );

    mod_counter_param #(.WIDTH(W), .MODULUS(M), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .T(T), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear), .ovf_clr(ovf_clr),
        .Q(qv[1]), .tc(tcv[1]), .ovf(ovfv[1])
    );

    mod_counter_param #(.WIDTH(W), .MODULUS(M), .SATURATE(0), .PRESCALE(3)) u_pre (
        .clk(clk), .reset_n(reset_n), .T(T), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear), .ovf_clr(ovf_clr),
        .Q(qv[2]), .tc(tcv[2]), .ovf(ovfv[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NDUT; i++) begin
            mq[i] = 0; mpc[i] = 0; mtc[i] = 0; movf[i] = 0;
        end
    endtask

    // One clock edge of the counter described in terms of modular arithmetic
    task automatic modelStep(input int i);
        int  target;
        bit  tk;
        bit  ev;
        ev = 1'b0;
        if (clear) begin
            mq[i]  = 0;
            mpc[i] = 0;
        end else if (load) begin
            mq[i]  = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
            mpc[i] = 0;
        end else begin
            tk = 1'b0;
            if (T) begin
                mpc[i] = (mpc[i] + 1) % mpre[i];
                tk     = (mpc[i] == 0);
            end
            if (tk) begin
                target = up_dn ? mq[i] + 1 : mq[i] - 1;
                if (target < 0 || target >= M) begin
                    ev    = 1'b1;
                    mq[i] = msat[i] ? mq[i] : (target + M) % M;
                end else begin
                    mq[i] = target;
                end
            end
        end
        mtc[i] = ev;
        if (ev) movf[i] = 1;
        else if (ovf_clr) movf[i] = 0;
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("%s_q%0d", tag, i),   32'(qv[i]),   32'(mq[i]));
            checkOutput($sformatf("%s_tc%0d", tag, i),  32'(tcv[i]),  32'(mtc[i]));
            checkOutput($sformatf("%s_ovf%0d", tag, i), 32'(ovfv[i]), 32'(movf[i]));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model and compare
    task automatic applyStimulus(input string tag, input logic t, input logic ud,
                                 input logic ld, input logic [W-1:0] lv,
                                 input logic clr, input logic oc);
        @(negedge clk);
        T = t; up_dn = ud; load = ld; load_val = lv; clear = clr; ovf_clr = oc;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) modelStep(i);
        #1;
        checkAll(tag);
    endtask

    initial begin
        modelReset();
        #12;
        checkAll("reset");
        @(negedge clk);
        T = 1'b1; up_dn = 1'b1;
        reset_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) modelStep(i);
        #1;
        checkAll("first");
        checkOutput("first_q_const", 32'(qv[0]), 32'd1);

        // Count up through the wrap
        for (int k = 0; k < 11; k++) applyStimulus("up", 1, 1, 0, 0, 0, 0);
        checkOutput("up_wrap_q_const", 32'(qv[0]), 32'd2);
        checkOutput("up_wrap_ovf_const", 32'(ovfv[0]), 32'd1);
        checkOutput("sat_hold_const", 32'(qv[1]), 32'd9);

        // Down through zero, clear ovf, then clear and boundary together
        applyStimulus("clr0", 0, 0, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) applyStimulus("down", 1, 0, 0, 0, 0, 0);
        applyStimulus("ovfclr", 0, 0, 0, 0, 0, 1);
        checkOutput("ovfclr_const", 32'(ovfv[0]), 32'd0);
        applyStimulus("ld0", 0, 0, 1, 0, 0, 0);
        applyStimulus("ovfclr_ev", 1, 0, 0, 0, 0, 1);
        checkOutput("ovfclr_ev_const", 32'(ovfv[0]), 32'd1);
        checkOutput("ovfclr_ev_q_const", 32'(qv[0]), 32'd9);

        // Saturate down at zero for several cycles
        applyStimulus("ld0b", 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus("satdn", 1, 0, 0, 0, 0, 0);

        // Load behaviour
        applyStimulus("ld4", 0, 1, 1, 4, 0, 0);
        applyStimulus("ld7", 1, 1, 1, 7, 0, 0);
        checkOutput("ld7_const", 32'(qv[0]), 32'd7);
        applyStimulus("ld13", 1, 1, 1, 13, 0, 0);
        checkOutput("ld13_const", 32'(qv[0]), 32'd9);
        applyStimulus("clrld", 1, 1, 1, 5, 1, 0);
        checkOutput("clrld_const", 32'(qv[0]), 32'd0);

        // Prescaler phase: run, pause mid-period, resume, then restart with load
        for (int k = 0; k < 4; k++) applyStimulus("pre", 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) applyStimulus("prehold", 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus("preres", 1, 1, 0, 0, 0, 0);
        applyStimulus("preld", 1, 1, 1, 2, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus("prephase", 1, 1, 0, 0, 0, 0);
        checkOutput("prephase_const", 32'(qv[2]), 32'd3);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            applyStimulus("rand",
                          logic'($urandom_range(0, 3) != 0),
                          logic'((k / 23) % 2 == 0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0)),
                          logic'($urandom_range(0, 15) == 0),
                          W'($urandom_range(0, 15)),
                          logic'($urandom_range(0, 24) == 0),
                          logic'($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset mid-count
        applyStimulus("ld6", 0, 1, 1, 6, 0, 0);
        @(negedge clk);
        T = 1'b0; load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll("async");
        checkOutput("async_q_const", 32'(qv[0]), 32'd0);
        @(negedge clk);
        T = 1'b1; up_dn = 1'b1; clear = 1'b0; ovf_clr = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) modelStep(i);
        #1;
        checkAll("release");
        checkOutput("release_q_const", 32'(qv[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
